// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front-end stall/flush controller.
package pipe_pkg;

  localparam int          CTRL_W    = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One action is selected per cycle; priority FREEZE > STALL > FLUSH > RUN.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } action_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with hold and synchronous clear.
// hold_i has priority over clr_i, which has priority over inc_i.
module sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: freeze, clear, or increment until MAX is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Front-end pipeline control: gates the PC write, holds/flushes IF/ID,
// injects bubbles into ID/EX, and keeps a stall watchdog plus stall/flush
// performance counters.
module pipe_stall_ctrl #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int WD_MAX = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_stall,
  input  logic              ID_redirect,
  input  logic              mem_busy,
  input  logic [31:0]       IF_pc,
  input  logic [31:0]       IF_instr,
  input  logic [CTRL_W-1:0] ID_ctrl,
  output logic              pc_write_en,
  output logic [31:0]       ID_pc,
  output logic [31:0]       ID_instr,
  output logic              ID_valid,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic              EX_valid,
  output logic              wd_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import pipe_pkg::*;

  localparam int WD_CW = $clog2(WD_MAX + 1);

  action_e           state_q;
  action_e           action_d;
  logic              pc_we_d;

  logic [31:0]       id_pc_q;
  logic [31:0]       id_instr_q;
  logic              id_valid_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic              ex_valid_q;
  logic              wd_timeout_q;
  logic              wd_timeout_d;

  logic [CTRL_W-1:0] ex_ctrl_gated;
  logic [WD_CW-1:0]  wd_cnt;
  logic              wd_sat;
  logic              stall_sat;
  logic              flush_sat;

  // Action decision depends only on this cycle's requests, never on state_q.
  always_comb begin
    action_d = RUN;
    pc_we_d  = 1'b1;
    if (mem_busy) begin
      action_d = FREEZE;
      pc_we_d  = 1'b0;
    end else if (hazard_stall) begin
      action_d = STALL;
      pc_we_d  = 1'b0;
    end else if (ID_redirect) begin
      action_d = FLUSH;
      pc_we_d  = 1'b1;
    end
  end

  // Last-action register, visible to debug through hierarchy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= action_d;
  end

  // The PC is allowed to load while reset is held.
  assign pc_write_en = !rst_n || pc_we_d;

  // An empty ID slot must never carry live control into EX.
  assign ex_ctrl_gated = id_valid_q ? ID_ctrl : '0;

  // IF/ID and ID/EX pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      case (action_d)
        FREEZE: begin
          id_pc_q    <= id_pc_q;
          id_instr_q <= id_instr_q;
          id_valid_q <= id_valid_q;
          ex_ctrl_q  <= ex_ctrl_q;
          ex_valid_q <= ex_valid_q;
        end
        STALL: begin
          ex_ctrl_q  <= '0;
          ex_valid_q <= 1'b0;
        end
        FLUSH: begin
          id_pc_q    <= IF_pc;
          id_instr_q <= NOP_INSTR;
          id_valid_q <= 1'b0;
          ex_ctrl_q  <= ex_ctrl_gated;
          ex_valid_q <= id_valid_q;
        end
        default: begin
          id_pc_q    <= IF_pc;
          id_instr_q <= IF_instr;
          id_valid_q <= 1'b1;
          ex_ctrl_q  <= ex_ctrl_gated;
          ex_valid_q <= id_valid_q;
        end
      endcase
    end
  end

  // Watchdog fires on the stall cycle that brings the run count to WD_MAX.
  always_comb begin
    wd_timeout_d = wd_timeout_q;
    if ((action_d == STALL) && (wd_sat || (wd_cnt == WD_CW'(WD_MAX - 1)))) begin
      wd_timeout_d = 1'b1;
    end
  end

  // Sticky watchdog flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_timeout_q <= 1'b0;
    else        wd_timeout_q <= wd_timeout_d;
  end

  sat_counter #(
    .W   (WD_CW),
    .MAX (WD_CW'(WD_MAX))
  ) u_wd_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (action_d == FREEZE),
    .clr_i  ((action_d == RUN) || (action_d == FLUSH)),
    .inc_i  (action_d == STALL),
    .cnt_o  (wd_cnt),
    .sat_o  (wd_sat)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ('1)
  ) u_stall_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (1'b0),
    .clr_i  (1'b0),
    .inc_i  (action_d == STALL),
    .cnt_o  (stall_cnt),
    .sat_o  (stall_sat)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ('1)
  ) u_flush_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (1'b0),
    .clr_i  (1'b0),
    .inc_i  (action_d == FLUSH),
    .cnt_o  (flush_cnt),
    .sat_o  (flush_sat)
  );

  assign ID_pc      = id_pc_q;
  assign ID_instr   = id_instr_q;
  assign ID_valid   = id_valid_q;
  assign EX_ctrl    = ex_ctrl_q;
  assign EX_valid   = ex_valid_q;
  assign wd_timeout = wd_timeout_q;

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

- Consumes the hazard stall request and the ID-stage redirect.
- Executes them on the front of the pipeline:
  - gates the PC write,
  - holds or flushes the IF/ID register,
  - injects bubbles into the ID/EX control register.
- Sits between the hazard detector, the ID-stage branch/jump resolver and the data-memory wait line.
- Also runs a stall watchdog and performance counters for stalls and flushes.

## Interface
Parameters:
- CTRL_W, 16: width of the decoded control bundle passed ID→EX; all-zero means no-op (no regWrite, no memWrite, no memToReg).
- WD_MAX, 64: consecutive hazard-stall cycles before the watchdog fires.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1: pipeline clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- hazard_stall  in  1: load-use / branch-operand stall request from the hazard detector.
- ID_redirect  in  1: taken jump/branch resolved in ID; next PC is the target.
- mem_busy  in  1: data memory not ready; whole pipeline freezes.
- IF_pc  in  32: PC of the instruction in IF.
- IF_instr  in  32: fetched instruction.
- ID_ctrl  in  CTRL_W: decoder control bundle for the instruction in ID.
- pc_write_en  out  1: PC register load enable (combinational).
- ID_pc  out  32: IF/ID register, PC.
- ID_instr  out  32: IF/ID register, instruction.
- ID_valid  out  1: IF/ID register, slot holds a real instruction.
- EX_ctrl  out  CTRL_W: ID/EX control register.
- EX_valid  out  1: ID/EX slot holds a real instruction.
- wd_timeout  out  1: sticky; hazard stall exceeded WD_MAX cycles.
- stall_cnt  out  CNT_W: hazard-stall cycles counted.
- flush_cnt  out  CNT_W: redirect flushes counted.

## Operation
Each cycle the FSM selects exactly one action. Priority is FREEZE > STALL > FLUSH > RUN.

- FREEZE (`mem_busy=1`):
  - pc_write_en=0.
  - IF/ID and ID/EX hold.
  - Counters and watchdog hold.
  - hazard_stall and ID_redirect are ignored this cycle; both re-evaluate when mem_busy drops.
- STALL (`hazard_stall=1`, `mem_busy=0`):
  - pc_write_en=0.
  - IF/ID holds.
  - ID/EX loads a bubble: EX_ctrl←0, EX_valid←0.
  - stall_cnt increments.
  - ID_redirect in the same cycle is ignored; the resolver re-asserts it once operands are available.
- FLUSH (`ID_redirect=1`, no stall, no freeze):
  - pc_write_en=1 (PC loads the target, selected outside this block).
  - IF/ID loads a bubble: ID_instr←0 (NOP), ID_valid←0, ID_pc←IF_pc.
  - ID/EX loads ID_ctrl, gated by ID_valid, with EX_valid←ID_valid.
  - flush_cnt increments.
- RUN:
  - pc_write_en=1.
  - IF/ID←{IF_pc, IF_instr, 1}.
  - ID/EX←{ID_ctrl gated by ID_valid, ID_valid}.
- Gating rule: EX_ctrl always loads 0 when ID_valid=0, so an invalid slot never writes registers or memory.
- Watchdog:
  - An internal run counter increments on each STALL cycle, clears on any RUN or FLUSH cycle, and holds on FREEZE.
  - When it reaches WD_MAX, wd_timeout sets and stays set until reset.
  - The counter saturates at WD_MAX.
- Counters saturate at all-ones; no wrap.
- State register tracks the last action (RUN, STALL, FLUSH, FREEZE) and is exposed to the bench via hierarchy only. Outputs depend on the current-cycle inputs, not on the previous state.

## Timing
- pc_write_en is purely combinational from mem_busy, hazard_stall and ID_redirect, with zero latency. It is 1 during reset.
- All other outputs are registered and update on the rising edge of clk after the decision.
- A bubble appears in EX one cycle after the STALL cycle.
- Reset values:
  - ID_pc, ID_instr, ID_valid, EX_ctrl, EX_valid, wd_timeout, stall_cnt, flush_cnt, watchdog counter: all 0.
  - FSM state: RUN.
- Reset asserted mid-stall or mid-freeze clears everything immediately. The first edge after release is a normal RUN/STALL/FLUSH decision.
- Load-use: one asserted hazard_stall cycle yields exactly one EX bubble, and the stalled instruction enters EX on the following edge.

## Structure
- Shared package `pipe_pkg`: CTRL_W, the NOP encoding 32'h0000_0000, and the action enum {RUN, STALL, FLUSH, FREEZE}.
- One natural sub-module, `sat_counter` (parameterised width, inc, hold, sat), instantiated for stall_cnt, flush_cnt and the watchdog run counter.

## Test plan
- Reset with IF_instr=32'h8C22_0004 presented → all registered outputs 0, pc_write_en=1. The first edge after release gives ID_instr=32'h8C22_0004, ID_valid=1.
- Single-cycle hazard_stall with ID_ctrl=16'h00A5, ID_valid=1:
  - pc_write_en=0 that cycle.
  - Next edge: ID_instr unchanged, EX_ctrl=0, EX_valid=0, stall_cnt=1.
  - The following edge: EX_ctrl=16'h00A5.
- ID_redirect alone with IF_pc=32'h0000_0040 → next edge: ID_valid=0, ID_instr=0, ID_pc=32'h40, flush_cnt=1.
- hazard_stall and ID_redirect together → treated as STALL: ID_valid stays 1, flush_cnt unchanged, stall_cnt+1.
- mem_busy held 3 cycles while hazard_stall and ID_redirect are high → pc_write_en=0, all registers and counters frozen for all 3 cycles.
- hazard_stall held 64 cycles with WD_MAX=64 → wd_timeout=1 after the 64th edge and stays 1 after the stall clears. Only rst_n=0 clears it, asynchronously.
